// File: rtl/spimemio_target.sv
// rtl/spimemio_target.sv - SPI flash responder serving read commands from a byte-wide memory port
// Optional dual-output read (0x3B) is enabled by defining SPIMEMIO_TARGET_DUAL_EN.
module spimemio_target #(
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flash_csb,
    input  logic              flash_clk,
    input  logic              flash_io0_di,
    output logic              flash_io0_do,
    output logic              flash_io0_oe,
    output logic              flash_io1_do,
    output logic              flash_io1_oe,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              underrun
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;

    logic [SYNC_STAGES-1:0] csb_sync_q, sclk_sync_q, mosi_sync_q;
    logic csb_prev_q, sclk_prev_q;
    logic csb_s, sclk_s, mosi_s;
    logic csb_rise, csb_fall, sclk_rise, sclk_fall;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [ADDR_W-2:0] sh_in_q, sh_in_d;
    logic              dummy_q, dummy_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        fall_cnt_q, fall_cnt_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              underrun_q, underrun_d;
    logic              io1_oe_q, io1_oe_d;
    logic              io0_oe_q, io0_oe_d;
    logic [7:0]        cmd_byte;
`ifdef SPIMEMIO_TARGET_DUAL_EN
    logic              dual_q, dual_d;
`endif

    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign csb_rise  = csb_s & ~csb_prev_q;
    assign csb_fall  = ~csb_s & csb_prev_q;
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csb_sync_q  <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            csb_prev_q  <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_in_q     <= '0;
            dummy_q     <= 1'b0;
            shift_q     <= '0;
            fall_cnt_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            underrun_q  <= 1'b0;
            io1_oe_q    <= 1'b0;
            io0_oe_q    <= 1'b0;
`ifdef SPIMEMIO_TARGET_DUAL_EN
            dual_q      <= 1'b0;
`endif
        end else begin
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], flash_csb};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], flash_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], flash_io0_di};
            csb_prev_q  <= csb_s;
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_in_q     <= sh_in_d;
            dummy_q     <= dummy_d;
            shift_q     <= shift_d;
            fall_cnt_q  <= fall_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            underrun_q  <= underrun_d;
            io1_oe_q    <= io1_oe_d;
            io0_oe_q    <= io0_oe_d;
`ifdef SPIMEMIO_TARGET_DUAL_EN
            dual_q      <= dual_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_in_d     = sh_in_q;
        dummy_d     = dummy_q;
        shift_d     = shift_q;
        fall_cnt_d  = fall_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        underrun_d  = underrun_q;
        io1_oe_d    = io1_oe_q;
        io0_oe_d    = io0_oe_q;
        cmd_byte    = {sh_in_q[6:0], mosi_s};
`ifdef SPIMEMIO_TARGET_DUAL_EN
        dual_d      = dual_q;
`endif
        // A returning byte lands in the holding register regardless of the state machine.
        if (mem_valid_q && mem_ready) begin
            hold_d      = mem_rdata;
            hold_full_d = 1'b1;
            mem_valid_d = 1'b0;
        end
        if (csb_rise) begin
            state_d     = IDLE;
            io1_oe_d    = 1'b0;
            io0_oe_d    = 1'b0;
            mem_valid_d = 1'b0;
            hold_full_d = 1'b0;
            shift_d     = '0;
        end else begin
            unique case (state_q)
                IDLE: if (csb_fall) begin
                    state_d    = CMD;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
                CMD: if (sclk_rise) begin
                    sh_in_d = {sh_in_q[ADDR_W-3:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        state_d = ADDR;
`ifdef SPIMEMIO_TARGET_DUAL_EN
                        dual_d  = 1'b0;
`endif
                        case (cmd_byte)
                            8'h03: dummy_d = 1'b0;
                            8'h0B: dummy_d = 1'b1;
`ifdef SPIMEMIO_TARGET_DUAL_EN
                            8'h3B: begin
                                dummy_d = 1'b1;
                                dual_d  = 1'b1;
                            end
`endif
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: if (sclk_rise) begin
                    sh_in_d = {sh_in_q[ADDR_W-3:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d       = '0;
                        mem_addr_d  = {sh_in_q, mosi_s};
                        mem_valid_d = 1'b1;
                        fall_cnt_d  = '0;
                        state_d     = dummy_q ? DUMMY : DATA;
                    end
                end
                DUMMY: if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) state_d = DATA;
                end
                DATA: if (sclk_fall) begin
                    if (fall_cnt_q == 3'd0) begin
                        io1_oe_d = 1'b1;
`ifdef SPIMEMIO_TARGET_DUAL_EN
                        io0_oe_d   = dual_q;
                        fall_cnt_d = dual_q ? 3'd3 : 3'd7;
`else
                        fall_cnt_d = 3'd7;
`endif
                        // An empty holding register means memory missed its deadline.
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                            mem_addr_d  = mem_addr_q + 1'b1;
                            mem_valid_d = 1'b1;
                        end else begin
                            shift_d    = 8'hFF;
                            underrun_d = 1'b1;
                        end
                    end else begin
                        fall_cnt_d = fall_cnt_q - 3'd1;
`ifdef SPIMEMIO_TARGET_DUAL_EN
                        shift_d = dual_q ? {shift_q[5:0], 2'b00} : {shift_q[6:0], 1'b0};
`else
                        shift_d = {shift_q[6:0], 1'b0};
`endif
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    assign flash_io1_do = shift_q[7];
    assign flash_io1_oe = io1_oe_q;
`ifdef SPIMEMIO_TARGET_DUAL_EN
    assign flash_io0_do = shift_q[6];
    assign flash_io0_oe = io0_oe_q;
`else
    assign flash_io0_do = 1'b0;
    assign flash_io0_oe = 1'b0;
`endif
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign underrun  = underrun_q;
endmodule

// File: tb/tb_spimemio_target.sv
// tb/tb_spimemio_target.sv - directed scoreboard bench for spimemio_target
module tb_spimemio_target;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        resetn, flash_csb, flash_clk, flash_io0_di;
    logic        flash_io0_do, flash_io0_oe, flash_io1_do, flash_io1_oe;
    logic        mem_valid, mem_ready, underrun;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:65535];
    logic [7:0]  exp_q [$];
    logic [15:0] req_q [$];
    int checks = 0, errors = 0;
    int half = 6, ready_lat = 1, wait_cnt = 0;
    int oe_cycles = 0, valid_cycles = 0;

    always #5 clk = ~clk;

    spimemio_target #(.ADDR_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetn(resetn), .flash_csb(flash_csb), .flash_clk(flash_clk),
        .flash_io0_di(flash_io0_di), .flash_io0_do(flash_io0_do), .flash_io0_oe(flash_io0_oe),
        .flash_io1_do(flash_io1_do), .flash_io1_oe(flash_io1_oe), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .underrun(underrun)
    );

    // Memory responder: ready after ready_lat clocks of mem_valid, data in the same cycle.
    always @(negedge clk) begin
        if (!resetn || !mem_valid) begin
            wait_cnt  = 0;
            mem_ready = 1'b0;
        end else if (wait_cnt >= ready_lat) begin
            if (!mem_ready) req_q.push_back(mem_addr);
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
        end else begin
            wait_cnt  = wait_cnt + 1;
            mem_ready = 1'b0;
        end
        if (flash_io1_oe || flash_io0_oe) oe_cycles = oe_cycles + 1;
        if (mem_valid) valid_cycles = valid_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hwait();
        repeat (half) @(posedge clk);
        #1;
    endtask

    task automatic spi_begin();
        flash_csb = 1'b0;
        hwait();
    endtask

    task automatic spi_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            flash_clk    = 1'b0;
            flash_io0_di = v[i];
            hwait();
            flash_clk = 1'b1;
            hwait();
        end
    endtask

    task automatic spi_dummy(input int n);
        for (int i = 0; i < n; i++) begin
            flash_clk = 1'b0;
            hwait();
            chk("dummy_oe", {30'd0, flash_io1_oe, flash_io0_oe}, 32'd0);
            flash_clk = 1'b1;
            hwait();
        end
    endtask

    task automatic spi_read_byte(input bit dual);
        logic [7:0] b;
        logic [7:0] e;
        int nb;
        b  = '0;
        nb = dual ? 4 : 8;
        for (int k = 0; k < nb; k++) begin
            flash_clk = 1'b0;
            hwait();
            if (k == 0) chk("data_oe", {30'd0, flash_io1_oe, flash_io0_oe}, dual ? 32'd3 : 32'd2);
            b = dual ? {b[5:0], flash_io1_do, flash_io0_do} : {b[6:0], flash_io1_do};
            flash_clk = 1'b1;
            hwait();
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("data_byte", {24'd0, b}, {24'd0, e});
    endtask

    task automatic spi_end();
        flash_csb = 1'b1;
        hwait();
        flash_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] a, input int n);
        logic [15:0] x;
        x = a;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[x]);
            x = x + 16'd1;
        end
    endtask

    initial begin
        int base, oe0, v0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C;
        mem[16'hFFFF] = 8'h81; mem[16'h0000] = 8'h7E;
        mem[16'h0020] = 8'hB4;
        resetn = 1'b0; flash_csb = 1'b1; flash_clk = 1'b0; flash_io0_di = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_io", {28'd0, flash_io0_do, flash_io0_oe, flash_io1_do, flash_io1_oe}, 32'd0);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Single read 0x03 @ 0x10
        base = req_q.size();
        push_exp(16'h0010, 2);
        spi_begin(); spi_bits(32'h03, 8); spi_bits(32'h000010, 24);
        spi_read_byte(0); spi_read_byte(0);
        chk("single_underrun", {31'd0, underrun}, 32'd0);
        spi_end();
        chk("single_nreq", req_q.size() - base, 32'd3);
        for (int k = 0; k < 3; k++) chk("single_req", {16'd0, req_q[base + k]}, 32'h10 + k);

        // Fast read 0x0B @ 0xFFFF with address wrap
        base = req_q.size();
        push_exp(16'hFFFF, 2);
        spi_begin(); spi_bits(32'h0B, 8); spi_bits(32'h00FFFF, 24); spi_dummy(8);
        spi_read_byte(0); spi_read_byte(0);
        spi_end();
        chk("fast_req0", {16'd0, req_q[base]}, 32'hFFFF);
        chk("fast_req1", {16'd0, req_q[base + 1]}, 32'h0000);

        // Unknown command is ignored, then a normal read
        oe0 = oe_cycles; v0 = valid_cycles;
        spi_begin(); spi_bits(32'h9F, 8); spi_bits(32'h0, 32); spi_end();
        chk("unk_oe", oe_cycles - oe0, 32'd0);
        chk("unk_valid", valid_cycles - v0, 32'd0);
        push_exp(16'h0004, 1);
        spi_begin(); spi_bits(32'h03, 8); spi_bits(32'h000004, 24); spi_read_byte(0); spi_end();

        // Abort mid-address
        spi_begin(); spi_bits(32'h03, 8); spi_bits(32'h000, 12);
        flash_csb = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        chk("abort_oe", {30'd0, flash_io1_oe, flash_io0_oe}, 32'd0);
        chk("abort_valid", {31'd0, mem_valid}, 32'd0);
        flash_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        push_exp(16'h0100, 2);
        spi_begin(); spi_bits(32'h03, 8); spi_bits(32'h000100, 24);
        spi_read_byte(0); spi_read_byte(0); spi_end();

        // Stall at clk/8: first byte underruns, pending byte used next
        half = 4; ready_lat = 40;
        exp_q.push_back(8'hFF);
        push_exp(16'h0030, 1);
        spi_begin(); spi_bits(32'h03, 8); spi_bits(32'h000030, 24);
        spi_read_byte(0); spi_read_byte(0);
        chk("stall_underrun", {31'd0, underrun}, 32'd1);
        spi_end();
        chk("underrun_sticky", {31'd0, underrun}, 32'd1);
        half = 6; ready_lat = 1;
        flash_csb = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        chk("underrun_clear", {31'd0, underrun}, 32'd0);
        hwait();
        push_exp(16'h0040, 1);
        spi_bits(32'h03, 8); spi_bits(32'h000040, 24); spi_read_byte(0);
        for (int k = 0; k < 3; k++) begin
            flash_clk = 1'b0; hwait(); flash_clk = 1'b1; hwait();
        end
        chk("pre_reset_oe", {31'd0, flash_io1_oe}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("async_rst_io", {28'd0, flash_io0_do, flash_io0_oe, flash_io1_do, flash_io1_oe}, 32'd0);
        chk("async_rst_mem", {15'd0, mem_valid, mem_addr}, 32'd0);
        flash_csb = 1'b1; flash_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

`ifdef SPIMEMIO_TARGET_DUAL_EN
        push_exp(16'h0020, 1);
        spi_begin(); spi_bits(32'h3B, 8); spi_bits(32'h000020, 24); spi_dummy(8);
        spi_read_byte(1); spi_end();
`else
        oe0 = oe_cycles; v0 = valid_cycles;
        spi_begin(); spi_bits(32'h3B, 8); spi_bits(32'h000020, 24); spi_bits(32'h0, 16); spi_end();
        chk("nodual_oe", oe_cycles - oe0, 32'd0);
        chk("nodual_valid", valid_cycles - v0, 32'd0);
`endif
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
